// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multicycle controller that takes one decoded instruction at a time from the
// decode stage and walks it through register-file read, ALU execute and
// writeback (IDLE -> READ -> EXEC -> WB -> IDLE, four cycles per instruction).
// It also owns the architectural 5-bit PSR {N, Z, L, F, C} (bits 4..0).
//
// Optional build macro: ALU_SEQ_ILLEGAL_TRAP_EN
//   When defined, an illegal opcode parks the FSM in a TRAP state after WB
//   (output trap high, issue_ready low) until trap_clr is seen.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   issue_*             decode handshake and instruction fields
//   rf_raddr_a/b        register-file read addresses (Rdest / Rsrc)
//   rf_rdata_a/b        register-file read data, one cycle after the address
//   rf_we/waddr/wdata   register-file write port, pulsed in WB
//   alu_alucont         ALU opcode, only non-zero in EXEC
//   alu_rdest/alu_rsrc  ALU operands, only non-zero in EXEC
//   alu_result/alu_psr  combinational ALU outputs
//   psr                 architectural flags, registered
//   done, done_illegal  one-cycle completion pulse and its illegal qualifier
//   trap, trap_clr      (ALU_SEQ_ILLEGAL_TRAP_EN only) trap status / release
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int WIDTH = 16,
   parameter int REGS  = 16,
   localparam int AW   = $clog2(REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [3:0]       issue_op,
   input  logic             issue_imm_sel,
   input  logic [AW-1:0]    issue_rdest,
   input  logic [AW-1:0]    issue_rsrc,
   input  logic [7:0]       issue_imm,
   output logic [AW-1:0]    rf_raddr_a,
   output logic [AW-1:0]    rf_raddr_b,
   input  logic [WIDTH-1:0] rf_rdata_a,
   input  logic [WIDTH-1:0] rf_rdata_b,
   output logic             rf_we,
   output logic [AW-1:0]    rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [3:0]       alu_alucont,
   output logic [WIDTH-1:0] alu_rsrc,
   output logic [WIDTH-1:0] alu_rdest,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [4:0]       alu_psr,
   output logic [4:0]       psr,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   input  logic             trap_clr,
   output logic             trap,
`endif
   output logic             done,
   output logic             done_illegal
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_CMP  = 4'd5;
   localparam logic [3:0] OP_MOV  = 4'd6;
   localparam logic [3:0] OP_LSH  = 4'd7;
   localparam logic [3:0] OP_LSHI = 4'd8;
   localparam logic [3:0] OP_LUI  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB,
      S_TRAP
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [3:0]        r_op;
   logic              r_immSel;
   logic [AW-1:0]     r_rdest;
   logic [AW-1:0]     r_rsrc;
   logic [7:0]        r_imm;

   logic              r_rfWe;
   logic [AW-1:0]     r_rfWaddr;
   logic [WIDTH-1:0]  r_rfWdata;
   logic [4:0]        r_psr;
   logic              r_done;
   logic              r_doneIllegal;

   logic              w_illegal;
   logic              w_inExec;
   logic [WIDTH-1:0]  w_extImm;
   logic [WIDTH-1:0]  w_luiVal;

   assign w_illegal = (r_op > OP_LUI);
   assign w_inExec  = (r_state == S_EXEC);
   assign w_luiVal  = {r_imm, {(WIDTH-8){1'b0}}};

   // State register; an asynchronous reset drops any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Instructions are only taken in IDLE, so issue_valid
   // seen while busy is simply ignored and the issuer keeps holding it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: if (issue_valid) w_nextState = S_READ;
         S_READ: w_nextState = S_EXEC;
         S_EXEC: w_nextState = S_WB;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
         S_WB:   w_nextState = w_illegal ? S_TRAP : S_IDLE;
         S_TRAP: if (trap_clr) w_nextState = S_IDLE;
`else
         S_WB:   w_nextState = S_IDLE;
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   // Capture the instruction fields on the accept cycle; they stay stable for
   // the rest of the instruction so the read addresses never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= '0;
         r_immSel <= 1'b0;
         r_rdest  <= '0;
         r_rsrc   <= '0;
         r_imm    <= '0;
      end else if (r_state == S_IDLE && issue_valid) begin
         r_op     <= issue_op;
         r_immSel <= issue_imm_sel;
         r_rdest  <= issue_rdest;
         r_rsrc   <= issue_rsrc;
         r_imm    <= issue_imm;
      end
   end

   // Immediate extension depends on the operation class: arithmetic and MOV
   // sign-extend, logic ops zero-extend, shifts keep only the 5-bit count
   // (bit 4 carries the LSHI direction).
   always_comb begin
      w_extImm = {{(WIDTH-8){1'b0}}, r_imm};
      case (r_op)
         OP_ADD, OP_SUB, OP_CMP, OP_MOV: w_extImm = {{(WIDTH-8){r_imm[7]}}, r_imm};
         OP_AND, OP_XOR, OP_OR:          w_extImm = {{(WIDTH-8){1'b0}}, r_imm};
         OP_LSH, OP_LSHI:                w_extImm = {{(WIDTH-5){1'b0}}, r_imm[4:0]};
         default:                        w_extImm = {{(WIDTH-8){1'b0}}, r_imm};
      endcase
   end

   // Output decode from the current state. The ALU sees a quiet all-zero
   // command except during EXEC of a legal op; LUI is executed as a MOV of
   // the pre-shifted immediate rather than using the ALU's own LUI encoding.
   always_comb begin
      issue_ready = (r_state == S_IDLE);
      alu_alucont = 4'b0000;
      alu_rdest   = '0;
      alu_rsrc    = '0;
      if (w_inExec && !w_illegal) begin
         if (r_op == OP_LUI) begin
            alu_alucont = OP_MOV;
            alu_rdest   = w_luiVal;
            alu_rsrc    = w_luiVal;
         end else begin
            alu_alucont = r_op;
            alu_rdest   = rf_rdata_a;
            alu_rsrc    = r_immSel ? w_extImm : rf_rdata_b;
         end
      end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      trap = (r_state == S_TRAP);
`endif
   end

   // Writeback and flag registers are loaded at the end of EXEC so they are
   // presented during WB; the write-enable and done pulses last exactly the
   // WB cycle. CMP updates only L/Z/N and never writes, ADD/SUB update only
   // C/F, and an illegal op touches nothing but done/done_illegal.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rfWe        <= 1'b0;
         r_rfWaddr     <= '0;
         r_rfWdata     <= '0;
         r_psr         <= '0;
         r_done        <= 1'b0;
         r_doneIllegal <= 1'b0;
      end else begin
         r_done        <= w_inExec;
         r_doneIllegal <= w_inExec && w_illegal;
         r_rfWe        <= w_inExec && !w_illegal && (r_op != OP_CMP);
         if (w_inExec && !w_illegal) begin
            r_rfWaddr <= r_rdest;
            r_rfWdata <= alu_result;
            if (r_op == OP_ADD || r_op == OP_SUB) begin
               r_psr[1:0] <= alu_psr[1:0];
            end else if (r_op == OP_CMP) begin
               r_psr[4:2] <= alu_psr[4:2];
            end
         end
      end
   end

   assign rf_raddr_a   = r_rdest;
   assign rf_raddr_b   = r_rsrc;
   assign rf_we        = r_rfWe;
   assign rf_waddr     = r_rfWaddr;
   assign rf_wdata     = r_rfWdata;
   assign psr          = r_psr;
   assign done         = r_done;
   assign done_illegal = r_doneIllegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. Surrounds the sequencer with a
// behavioural register file (synchronous read) and a small combinational ALU
// model, runs directed instructions and compares writeback, flags and
// handshake timing against expectations held in a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic        issue_imm_sel;
   logic [3:0]  issue_rdest;
   logic [3:0]  issue_rsrc;
   logic [7:0]  issue_imm;
   logic [3:0]  rf_raddr_a;
   logic [3:0]  rf_raddr_b;
   logic [15:0] rf_rdata_a;
   logic [15:0] rf_rdata_b;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [3:0]  alu_alucont;
   logic [15:0] alu_rsrc;
   logic [15:0] alu_rdest;
   logic [15:0] alu_result;
   logic [4:0]  alu_psr;
   logic [4:0]  psr;
   logic        done;
   logic        done_illegal;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic        trap_clr;
   logic        trap;
`endif

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic        we;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      logic [4:0]  psr;
      logic        ill;
   } exp_t;

   exp_t sbQ[$];

   logic [15:0] rfMem [16];
   logic        preloadEn;
   logic [3:0]  preloadAddr;
   logic [15:0] preloadData;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_op      (issue_op),
      .issue_imm_sel (issue_imm_sel),
      .issue_rdest   (issue_rdest),
      .issue_rsrc    (issue_rsrc),
      .issue_imm     (issue_imm),
      .rf_raddr_a    (rf_raddr_a),
      .rf_raddr_b    (rf_raddr_b),
      .rf_rdata_a    (rf_rdata_a),
      .rf_rdata_b    (rf_rdata_b),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .alu_alucont   (alu_alucont),
      .alu_rsrc      (alu_rsrc),
      .alu_rdest     (alu_rdest),
      .alu_result    (alu_result),
      .alu_psr       (alu_psr),
      .psr           (psr),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      .trap_clr      (trap_clr),
      .trap          (trap),
`endif
      .done          (done),
      .done_illegal  (done_illegal)
   );

   // Register file model: synchronous read, write from the DUT or a preload.
   always @(posedge clk) begin
      rf_rdata_a <= rfMem[rf_raddr_a];
      rf_rdata_b <= rfMem[rf_raddr_b];
      if (rf_we) rfMem[rf_waddr] <= rf_wdata;
      if (preloadEn) rfMem[preloadAddr] <= preloadData;
   end

   // ALU model; flag bits are {N, Z, L, F, C}.
   always_comb begin
      logic [16:0] sum;
      logic [4:0]  amt;
      sum        = '0;
      amt        = '0;
      alu_result = '0;
      alu_psr    = '0;
      case (alu_alucont)
         4'd0: begin
            sum        = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
            alu_result = sum[15:0];
            alu_psr[0] = sum[16];
            alu_psr[1] = (alu_rdest[15] == alu_rsrc[15]) && (alu_result[15] != alu_rdest[15]);
         end
         4'd1: begin
            alu_result = alu_rdest - alu_rsrc;
            alu_psr[0] = alu_rdest < alu_rsrc;
            alu_psr[1] = (alu_rdest[15] != alu_rsrc[15]) && (alu_result[15] != alu_rdest[15]);
         end
         4'd2: alu_result = alu_rdest & alu_rsrc;
         4'd3: alu_result = alu_rdest ^ alu_rsrc;
         4'd4: alu_result = alu_rdest | alu_rsrc;
         4'd5: begin
            alu_psr[2] = alu_rdest < alu_rsrc;
            alu_psr[3] = alu_rdest == alu_rsrc;
            alu_psr[4] = $signed(alu_rdest) < $signed(alu_rsrc);
         end
         4'd6: alu_result = alu_rsrc;
         4'd7, 4'd8: begin
            if (alu_rsrc[4]) begin
               amt        = 5'd0 - alu_rsrc[4:0];
               alu_result = alu_rdest >> amt;
            end else begin
               alu_result = alu_rdest << alu_rsrc[3:0];
            end
         end
         default: alu_result = '0;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] addr, input logic [15:0] data);
      @(negedge clk);
      preloadEn   = 1'b1;
      preloadAddr = addr;
      preloadData = data;
      @(negedge clk);
      preloadEn   = 1'b0;
   endtask

   // One complete instruction with per-phase checks; the writeback
   // expectation travels through the scoreboard and is popped on done.
   task automatic applyStimulus(input string name, input logic [3:0] op, input logic immSel,
                                input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm,
                                input logic [3:0] expAlucont, input logic [15:0] expAluRsrc,
                                input logic expWe, input logic [15:0] expWdata,
                                input logic [4:0] expPsr, input logic expIll);
      exp_t e;
      int   cycles;
      logic expReadyT4;
      expReadyT4 = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      if (expIll) expReadyT4 = 1'b0;
`endif
      @(negedge clk);
      checkOutput({name, "_ready_idle"}, 32'(issue_ready), 32'd1);
      issue_op      = op;
      issue_imm_sel = immSel;
      issue_rdest   = rd;
      issue_rsrc    = rs;
      issue_imm     = imm;
      issue_valid   = 1'b1;
      e.we = expWe; e.waddr = rd; e.wdata = expWdata; e.psr = expPsr; e.ill = expIll;
      sbQ.push_back(e);
      @(negedge clk);
      issue_valid = 1'b0;
      checkOutput({name, "_ready_read"}, 32'(issue_ready), 32'd0);
      checkOutput({name, "_raddr_a"}, 32'(rf_raddr_a), 32'(rd));
      checkOutput({name, "_raddr_b"}, 32'(rf_raddr_b), 32'(rs));
      checkOutput({name, "_alucont_read"}, 32'(alu_alucont), 32'd0);
      @(negedge clk);
      checkOutput({name, "_alucont"}, 32'(alu_alucont), 32'(expAlucont));
      checkOutput({name, "_alu_rsrc"}, 32'(alu_rsrc), 32'(expAluRsrc));
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < 8);
      checkOutput({name, "_done_latency"}, 32'(cycles), 32'd1);
      if (done && sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkOutput({name, "_we"}, 32'(rf_we), 32'(e.we));
         if (e.we) begin
            checkOutput({name, "_waddr"}, 32'(rf_waddr), 32'(e.waddr));
            checkOutput({name, "_wdata"}, 32'(rf_wdata), 32'(e.wdata));
         end
         checkOutput({name, "_psr"}, 32'(psr), 32'(e.psr));
         checkOutput({name, "_done_illegal"}, 32'(done_illegal), 32'(e.ill));
      end
      @(negedge clk);
      checkOutput({name, "_done_t4"}, 32'(done), 32'd0);
      checkOutput({name, "_we_t4"}, 32'(rf_we), 32'd0);
      checkOutput({name, "_ready_t4"}, 32'(issue_ready), 32'(expReadyT4));
   endtask

   initial begin
      int doneSeen;
      int weSeen;
      int acceptCycles[$];
      int doneCnt;

      reset         = 1'b0;
      issue_valid   = 1'b0;
      issue_op      = '0;
      issue_imm_sel = 1'b0;
      issue_rdest   = '0;
      issue_rsrc    = '0;
      issue_imm     = '0;
      preloadEn     = 1'b0;
      preloadAddr   = '0;
      preloadData   = '0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      trap_clr      = 1'b0;
`endif

      preload(4'd0,  16'h0000);
      preload(4'd1,  16'h7FFF);
      preload(4'd2,  16'h0001);
      preload(4'd3,  16'h0005);
      preload(4'd4,  16'h0009);
      preload(4'd5,  16'hFFFF);
      preload(4'd6,  16'h1234);
      preload(4'd7,  16'h0001);
      preload(4'd8,  16'h0010);
      preload(4'd9,  16'h0000);
      preload(4'd10, 16'hFFFF);

      @(negedge clk);
      checkOutput("rst_ready", 32'(issue_ready), 32'd1);
      checkOutput("rst_we", 32'(rf_we), 32'd0);
      checkOutput("rst_waddr", 32'(rf_waddr), 32'd0);
      checkOutput("rst_wdata", 32'(rf_wdata), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_done_illegal", 32'(done_illegal), 32'd0);
      checkOutput("rst_psr", 32'(psr), 32'd0);
      checkOutput("rst_alucont", 32'(alu_alucont), 32'd0);
      reset = 1'b1;

      //            name     op    isel rd     rs     imm    alucont rsrc      we    wdata     psr      ill
      applyStimulus("add",   4'd0, 0, 4'd1,  4'd2,  8'h00, 4'd0, 16'h0001, 1'b1, 16'h8000, 5'h02, 1'b0);
      applyStimulus("cmp",   4'd5, 0, 4'd3,  4'd4,  8'h00, 4'd5, 16'h0009, 1'b0, 16'h0000, 5'h16, 1'b0);
      applyStimulus("andi",  4'd2, 1, 4'd5,  4'd0,  8'h80, 4'd2, 16'h0080, 1'b1, 16'h0080, 5'h16, 1'b0);
      applyStimulus("addi",  4'd0, 1, 4'd2,  4'd0,  8'h80, 4'd0, 16'hFF80, 1'b1, 16'hFF81, 5'h14, 1'b0);
      applyStimulus("lui",   4'd9, 0, 4'd6,  4'd0,  8'hA5, 4'd6, 16'hA500, 1'b1, 16'hA500, 5'h14, 1'b0);
      applyStimulus("lshi",  4'd8, 1, 4'd7,  4'd0,  8'h03, 4'd8, 16'h0003, 1'b1, 16'h0008, 5'h14, 1'b0);
      applyStimulus("xori",  4'd3, 1, 4'd10, 4'd0,  8'h80, 4'd3, 16'h0080, 1'b1, 16'hFF7F, 5'h14, 1'b0);
      applyStimulus("movi",  4'd6, 1, 4'd9,  4'd0,  8'hF0, 4'd6, 16'hFFF0, 1'b1, 16'hFFF0, 5'h14, 1'b0);
      applyStimulus("sub",   4'd1, 0, 4'd3,  4'd4,  8'h00, 4'd1, 16'h0009, 1'b1, 16'hFFFC, 5'h15, 1'b0);
      applyStimulus("xorrr", 4'd3, 0, 4'd8,  4'd8,  8'h00, 4'd3, 16'h0010, 1'b1, 16'h0000, 5'h15, 1'b0);
      applyStimulus("illeg", 4'hC, 0, 4'd8,  4'd0,  8'h00, 4'd0, 16'h0000, 1'b0, 16'h0000, 5'h15, 1'b1);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      checkOutput("trap_set", 32'(trap), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("trap_hold", 32'(trap), 32'd1);
      checkOutput("trap_ready_hold", 32'(issue_ready), 32'd0);
      trap_clr = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      checkOutput("trap_cleared", 32'(trap), 32'd0);
      checkOutput("trap_ready_back", 32'(issue_ready), 32'd1);
`endif

      // Reset during EXEC of an ADD aborts it without a write or done.
      @(negedge clk);
      issue_op = 4'd0; issue_imm_sel = 1'b0; issue_rdest = 4'd1; issue_rsrc = 4'd2;
      issue_valid = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort_exec_rdest", 32'(alu_rdest), 32'h8000);
      reset = 1'b0;
      #1;
      checkOutput("abort_ready", 32'(issue_ready), 32'd1);
      checkOutput("abort_psr", 32'(psr), 32'd0);
      checkOutput("abort_alucont", 32'(alu_alucont), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      doneSeen = 0;
      weSeen   = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) doneSeen++;
         if (rf_we) weSeen++;
         @(negedge clk);
      end
      checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
      checkOutput("abort_no_we", 32'(weSeen), 32'd0);
      checkOutput("abort_psr_after", 32'(psr), 32'd0);

      // Back-to-back: issue_valid held high, acceptance only every 4 cycles.
      issue_op = 4'd4; issue_imm_sel = 1'b0; issue_rdest = 4'd8; issue_rsrc = 4'd8;
      issue_valid = 1'b1;
      doneCnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (issue_ready) acceptCycles.push_back(i);
         if (done) doneCnt++;
         @(negedge clk);
      end
      issue_valid = 1'b0;
      checkOutput("b2b_accepts", 32'(acceptCycles.size()), 32'd3);
      if (acceptCycles.size() == 3) begin
         checkOutput("b2b_first", 32'(acceptCycles[0]), 32'd0);
         checkOutput("b2b_gap1", 32'(acceptCycles[1] - acceptCycles[0]), 32'd4);
         checkOutput("b2b_gap2", 32'(acceptCycles[2] - acceptCycles[1]), 32'd4);
      end
      checkOutput("b2b_dones", 32'(doneCnt), 32'd3);
      checkOutput("b2b_psr", 32'(psr), 32'd0);
      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
